// File: rtl/sys_cntr_rx.sv
// sys_cntr_rx: UART command frame decoder. Turns a stream of received bytes
// into register-file write/read strobes and ALU start/clock-gate control.
// Frames: 0xAA addr data | 0xBB addr | 0xCC opA opB fun | 0xDD fun.
module sys_cntr_rx #(
    parameter int width      = 8,
    parameter int addr_width = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [width-1:0]      Rx_Data,
    input  logic                  Rx_Data_valid,
    input  logic                  ALU_out_valid,
    output logic                  Wr_En,
    output logic                  Rd_En,
    output logic [addr_width-1:0] Address,
    output logic [width-1:0]      Wr_Data,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CLK_GATE_EN
);

    localparam logic [width-1:0] CMD_RF_WR   = width'(8'hAA);
    localparam logic [width-1:0] CMD_RF_RD   = width'(8'hBB);
    localparam logic [width-1:0] CMD_ALU_OP  = width'(8'hCC);
    localparam logic [width-1:0] CMD_ALU_NOP = width'(8'hDD);

    // 4-bit encoding leaves spare codes so an upset state is detectable
    // and steered back to IDLE by the default branch.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        OP_A     = 4'd4,
        OP_B     = 4'd5,
        FUN      = 4'd6,
        ALU_WAIT = 4'd7
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_wr_en,   w_wr_en_next;
    logic                  r_rd_en,   w_rd_en_next;
    logic                  r_alu_en,  w_alu_en_next;
    logic                  r_gate_en, w_gate_en_next;
    logic [addr_width-1:0] r_addr,    w_addr_next;
    logic [width-1:0]      r_wr_data, w_wr_data_next;
    logic [3:0]            r_alu_fun, w_alu_fun_next;

    // Next-state and next-output decode; strobes default low so each
    // accepted byte yields exactly one pulse, data outputs hold by default.
    always_comb begin
        w_state_next   = r_state;
        w_wr_en_next   = 1'b0;
        w_rd_en_next   = 1'b0;
        w_alu_en_next  = 1'b0;
        w_gate_en_next = r_gate_en;
        w_addr_next    = r_addr;
        w_wr_data_next = r_wr_data;
        w_alu_fun_next = r_alu_fun;
        case (r_state)
            IDLE: begin
                w_gate_en_next = 1'b0;
                if (Rx_Data_valid) begin
                    if (Rx_Data == CMD_RF_WR)        w_state_next = WR_ADDR;
                    else if (Rx_Data == CMD_RF_RD)   w_state_next = RD_ADDR;
                    else if (Rx_Data == CMD_ALU_OP)  w_state_next = OP_A;
                    else if (Rx_Data == CMD_ALU_NOP) w_state_next = FUN;
                end
            end
            WR_ADDR: begin
                if (Rx_Data_valid) begin
                    w_addr_next  = Rx_Data[addr_width-1:0];
                    w_state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                if (Rx_Data_valid) begin
                    w_wr_data_next = Rx_Data;
                    w_wr_en_next   = 1'b1;
                    w_state_next   = IDLE;
                end
            end
            RD_ADDR: begin
                if (Rx_Data_valid) begin
                    w_addr_next  = Rx_Data[addr_width-1:0];
                    w_rd_en_next = 1'b1;
                    w_state_next = IDLE;
                end
            end
            OP_A: begin
                if (Rx_Data_valid) begin
                    w_addr_next    = '0;
                    w_wr_data_next = Rx_Data;
                    w_wr_en_next   = 1'b1;
                    w_state_next   = OP_B;
                end
            end
            OP_B: begin
                if (Rx_Data_valid) begin
                    w_addr_next    = addr_width'(1);
                    w_wr_data_next = Rx_Data;
                    w_wr_en_next   = 1'b1;
                    w_state_next   = FUN;
                end
            end
            FUN: begin
                if (Rx_Data_valid) begin
                    w_alu_fun_next = Rx_Data[3:0];
                    w_alu_en_next  = 1'b1;
                    w_gate_en_next = 1'b1;
                    w_state_next   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                // Bytes arriving here are dropped, even alongside the result.
                w_gate_en_next = 1'b1;
                if (ALU_out_valid) begin
                    w_gate_en_next = 1'b0;
                    w_state_next   = IDLE;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_gate_en_next = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_alu_en  <= 1'b0;
            r_gate_en <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_alu_fun <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wr_en   <= w_wr_en_next;
            r_rd_en   <= w_rd_en_next;
            r_alu_en  <= w_alu_en_next;
            r_gate_en <= w_gate_en_next;
            r_addr    <= w_addr_next;
            r_wr_data <= w_wr_data_next;
            r_alu_fun <= w_alu_fun_next;
        end
    end

    assign Wr_En       = r_wr_en;
    assign Rd_En       = r_rd_en;
    assign ALU_EN      = r_alu_en;
    assign CLK_GATE_EN = r_gate_en;
    assign Address     = r_addr;
    assign Wr_Data     = r_wr_data;
    assign ALU_FUN     = r_alu_fun;

endmodule

// File: tb/tb_sys_cntr_rx.sv
// Testbench for sys_cntr_rx: frame-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sys_cntr_rx;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Rx_Data = 8'h00;
    logic       Rx_Data_valid = 1'b0;
    logic       ALU_out_valid = 1'b0;
    logic       Wr_En, Rd_En, ALU_EN, CLK_GATE_EN;
    logic [3:0] Address;
    logic [7:0] Wr_Data;
    logic [3:0] ALU_FUN;

    int n_checks = 0;
    int n_pass   = 0;

    sys_cntr_rx #(.width(8), .addr_width(4)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Rx_Data      (Rx_Data),
        .Rx_Data_valid(Rx_Data_valid),
        .ALU_out_valid(ALU_out_valid),
        .Wr_En        (Wr_En),
        .Rd_En        (Rd_En),
        .Address      (Address),
        .Wr_Data      (Wr_Data),
        .ALU_EN       (ALU_EN),
        .ALU_FUN      (ALU_FUN),
        .CLK_GATE_EN  (CLK_GATE_EN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
    endtask

    // Reference model: the frame collected so far (first byte + count of
    // bytes received) decides what each new byte means.
    logic       m_wr = 0, m_rd = 0, m_alu = 0, m_gate = 0, m_busy = 0;
    logic [3:0] m_addr = 0, m_fun = 0;
    logic [7:0] m_wdata = 0, m_cmd = 0;
    int         m_n = 0;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_wr <= 0; m_rd <= 0; m_alu <= 0; m_gate <= 0; m_busy <= 0;
            m_addr <= 0; m_fun <= 0; m_wdata <= 0; m_cmd <= 0; m_n <= 0;
        end else begin
            m_wr <= 0; m_rd <= 0; m_alu <= 0;
            if (m_busy) begin
                if (ALU_out_valid) begin
                    m_busy <= 0;
                    m_gate <= 0;
                end
            end else if (Rx_Data_valid) begin
                if (m_n == 0) begin
                    if (Rx_Data inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
                        m_cmd <= Rx_Data;
                        m_n   <= 1;
                    end
                end else begin
                    case (m_cmd)
                        8'hAA: if (m_n == 1) begin m_addr <= Rx_Data[3:0]; m_n <= 2; end
                               else begin m_wdata <= Rx_Data; m_wr <= 1; m_n <= 0; end
                        8'hBB: begin m_addr <= Rx_Data[3:0]; m_rd <= 1; m_n <= 0; end
                        8'hCC: if (m_n == 1) begin m_addr <= 0; m_wdata <= Rx_Data; m_wr <= 1; m_n <= 2; end
                               else if (m_n == 2) begin m_addr <= 1; m_wdata <= Rx_Data; m_wr <= 1; m_n <= 3; end
                               else begin m_fun <= Rx_Data[3:0]; m_alu <= 1; m_gate <= 1; m_busy <= 1; m_n <= 0; end
                        default: begin m_fun <= Rx_Data[3:0]; m_alu <= 1; m_gate <= 1; m_busy <= 1; m_n <= 0; end
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge CLK) begin
        #2;
        check("cyc_wr_en",   32'(Wr_En),       32'(m_wr));
        check("cyc_rd_en",   32'(Rd_En),       32'(m_rd));
        check("cyc_alu_en",  32'(ALU_EN),      32'(m_alu));
        check("cyc_gate_en", 32'(CLK_GATE_EN), 32'(m_gate));
        check("cyc_address", 32'(Address),     32'(m_addr));
        check("cyc_wr_data", 32'(Wr_Data),     32'(m_wdata));
        check("cyc_alu_fun", 32'(ALU_FUN),     32'(m_fun));
    end

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        Rx_Data = b;
        Rx_Data_valid = 1'b1;
        $display("tx byte 0x%02h t=%0t", b, $time);
        @(negedge CLK);
        Rx_Data_valid = 1'b0;
    endtask

    task automatic pulse_alu();
        @(negedge CLK);
        ALU_out_valid = 1'b1;
        @(negedge CLK);
        ALU_out_valid = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_wr_en", 32'(Wr_En), 0);
        check("rst_address", 32'(Address), 0);
        check("rst_gate", 32'(CLK_GATE_EN), 0);
        Reset = 1'b0;

        // RF write frame
        send(8'hAA); send(8'h05);
        check("wr_no_early", 32'(Wr_En), 0);
        send(8'h3C);
        check("wr_en", 32'(Wr_En), 1);
        check("wr_addr", 32'(Address), 5);
        check("wr_data", 32'(Wr_Data), 32'h3C);
        check("wr_rd_quiet", 32'(Rd_En), 0);
        @(negedge CLK);
        check("wr_one_cycle", 32'(Wr_En), 0);
        check("wr_data_hold", 32'(Wr_Data), 32'h3C);

        // RF read frame
        send(8'hBB); send(8'h07);
        check("rd_en", 32'(Rd_En), 1);
        check("rd_addr", 32'(Address), 7);
        check("rd_wr_quiet", 32'(Wr_En), 0);

        // ALU with operands, back-to-back bytes
        @(negedge CLK); Rx_Data = 8'hCC; Rx_Data_valid = 1'b1;
        @(negedge CLK); Rx_Data = 8'h10;
        @(negedge CLK); Rx_Data = 8'h20;
        check("opa_wr", 32'(Wr_En), 1);
        check("opa_addr", 32'(Address), 0);
        check("opa_data", 32'(Wr_Data), 32'h10);
        @(negedge CLK); Rx_Data = 8'h01;
        check("opb_wr", 32'(Wr_En), 1);
        check("opb_addr", 32'(Address), 1);
        check("opb_data", 32'(Wr_Data), 32'h20);
        @(negedge CLK); Rx_Data_valid = 1'b0;
        check("fun_alu_en", 32'(ALU_EN), 1);
        check("fun_code", 32'(ALU_FUN), 1);
        check("fun_gate", 32'(CLK_GATE_EN), 1);
        @(negedge CLK);
        check("wait_gate", 32'(CLK_GATE_EN), 1);
        check("wait_alu_low", 32'(ALU_EN), 0);
        pulse_alu();
        check("done_gate", 32'(CLK_GATE_EN), 0);

        // junk byte then ALU without operands
        send(8'h55);
        check("junk_wr", 32'(Wr_En), 0);
        check("junk_alu", 32'(ALU_EN), 0);
        send(8'hDD); send(8'h0A);
        check("nop_alu_en", 32'(ALU_EN), 1);
        check("nop_fun", 32'(ALU_FUN), 32'hA);
        pulse_alu();

        // reset mid-frame
        send(8'hAA); send(8'h03);
        Reset = 1'b1;
        #1;
        check("async_rst_addr", 32'(Address), 0);
        check("async_rst_data", 32'(Wr_Data), 0);
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        send(8'h3C);
        check("post_rst_no_wr", 32'(Wr_En), 0);
        check("post_rst_data", 32'(Wr_Data), 0);

        // byte dropped during ALU wait
        send(8'hDD); send(8'h03);
        send(8'hAA);
        check("drop_wr", 32'(Wr_En), 0);
        check("drop_gate", 32'(CLK_GATE_EN), 1);
        pulse_alu();
        check("drop_gate_off", 32'(CLK_GATE_EN), 0);
        send(8'hBB); send(8'h02);
        check("after_drop_rd", 32'(Rd_En), 1);
        check("after_drop_addr", 32'(Address), 2);

        // byte and ALU result in the same wait cycle: exit, byte dropped
        send(8'hDD); send(8'h05);
        @(negedge CLK);
        Rx_Data = 8'hBB; Rx_Data_valid = 1'b1; ALU_out_valid = 1'b1;
        @(negedge CLK);
        Rx_Data_valid = 1'b0; ALU_out_valid = 1'b0;
        check("coinc_gate", 32'(CLK_GATE_EN), 0);
        send(8'h07);
        check("coinc_no_rd", 32'(Rd_En), 0);
        check("coinc_addr_hold", 32'(Address), 2);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
